// File: rtl/tl_buffer_queue_pkg.sv
// tl_buffer_pkg: shared TileLink-UL types and constants for tl_buffer_queue.
//   tl_a_t / tl_d_t : packed A/D channel payloads (widths from the constants below)
//   TL_*_W          : default field widths
//   TL_A_* / TL_D_* : opcode encodings used by this node's users
//   cnt_w()         : width of an occupancy counter for a given depth (min 1 bit)
package tl_buffer_pkg;

  localparam int unsigned TL_ADDR_W = 29;
  localparam int unsigned TL_DATA_W = 64;
  localparam int unsigned TL_MASK_W = TL_DATA_W / 8;
  localparam int unsigned TL_SRC_W  = 6;
  localparam int unsigned TL_SIZE_W = 4;
  localparam int unsigned TL_SINK_W = 1;

  localparam logic [2:0] TL_A_PUTFULL        = 3'd0;
  localparam logic [2:0] TL_A_GET            = 3'd4;
  localparam logic [2:0] TL_D_ACCESSACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA  = 3'd1;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_SINK_W-1:0] sink;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_d_t;

  // A depth-0 queue still gets a 1-bit (always zero) counter so ports stay legal.
  function automatic int cnt_w(int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tl_buffer_queue_if.sv
// tl_buffer_queue_if: one TileLink-UL A+D channel pair.
//   a_valid/a_ready/a_bits : A channel (master -> slave)
//   d_valid/d_ready/d_bits : D channel (slave -> master)
// Modports: master (issues A, accepts D), slave (accepts A, issues D).
interface tl_buffer_queue_if;
  logic                 a_valid;
  logic                 a_ready;
  tl_buffer_pkg::tl_a_t a_bits;
  logic                 d_valid;
  logic                 d_ready;
  tl_buffer_pkg::tl_d_t d_bits;

  modport master (output a_valid, a_bits, d_ready, input a_ready, d_valid, d_bits);
  modport slave  (input a_valid, a_bits, d_ready, output a_ready, d_valid, d_bits);
endinterface

// File: rtl/tl_buffer_queue_fifo.sv
// tl_buffer_fifo: generic valid/ready queue carrying payload type T.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   enq_valid_i/ready_o/bits_i : producer side
//   deq_valid_o/ready_i/bits_o : consumer side
//   count_o, hwm_o          : occupancy / high-water mark (TL_BUFFER_STATS_EN only)
// DEPTH=0 is a pure wire (FLOW/PIPE ignored). DEPTH>=1 is a circular buffer
// whose pointers wrap at DEPTH-1, so any depth 1..16 works.
module tl_buffer_fifo
  import tl_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter bit          FLOW  = 1'b0,
  parameter bit          PIPE  = 1'b0,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enq_valid_i,
  output logic enq_ready_o,
  input  T     enq_bits_i,
  output logic deq_valid_o,
  input  logic deq_ready_i,
  output T     deq_bits_o
`ifdef TL_BUFFER_STATS_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  output logic [cnt_w(DEPTH)-1:0] hwm_o
`endif
);

  localparam int CW = cnt_w(DEPTH);

  generate
    if (DEPTH == 0) begin : g_wire
      // Handshakes are still held low during reset.
      assign enq_ready_o = rst_ni && deq_ready_i;
      assign deq_valid_o = rst_ni && enq_valid_i;
      assign deq_bits_o  = enq_bits_i;
`ifdef TL_BUFFER_STATS_EN
      assign count_o = '0;
      assign hwm_o   = '0;
`endif
    end else begin : g_fifo
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
      localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

      T              mem_q [DEPTH];
      logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          empty, full, enq_fire, deq_fire, pass, do_wr, do_rd;

      assign empty = (cnt_q == '0);
      assign full  = (cnt_q == CW'(DEPTH));

      assign enq_ready_o = rst_ni && (!full || (PIPE && deq_ready_i));
      assign deq_valid_o = rst_ni && (!empty || (FLOW && enq_valid_i));
      // When empty in flow mode the producer's beat is what the consumer sees.
      assign deq_bits_o  = (FLOW && empty) ? enq_bits_i : mem_q[rd_q];

      assign enq_fire = enq_valid_i && enq_ready_o;
      assign deq_fire = deq_valid_o && deq_ready_i;
      // Both fire on an empty queue only via the flow bypass: nothing is stored.
      assign pass  = empty && enq_fire && deq_fire;
      assign do_wr = enq_fire && !pass;
      assign do_rd = deq_fire && !pass;

      always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_wr) begin
          wr_d  = (wr_q == LAST) ? '0 : wr_q + 1'b1;
          cnt_d = cnt_d + 1'b1;
        end
        if (do_rd) begin
          rd_d  = (rd_q == LAST) ? '0 : rd_q + 1'b1;
          cnt_d = cnt_d - 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          rd_q  <= '0;
          wr_q  <= '0;
          cnt_q <= '0;
        end else begin
          rd_q  <= rd_d;
          wr_q  <= wr_d;
          cnt_q <= cnt_d;
        end
      end

      // Storage carries no reset; occupancy alone decides what is valid.
      always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_q] <= enq_bits_i;
      end

`ifdef TL_BUFFER_STATS_EN
      logic [CW-1:0] hwm_q, hwm_d;
      // Tracks the registered count, so it trails count by one cycle.
      assign hwm_d = (cnt_q > hwm_q) ? cnt_q : hwm_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) hwm_q <= '0;
        else         hwm_q <= hwm_d;
      end
      assign count_o = cnt_q;
      assign hwm_o   = hwm_q;
`endif
    end
  endgenerate

endmodule

// File: rtl/tl_buffer_queue.sv
// tl_buffer_queue: TileLink-UL buffer node with independent A and D queues.
//   clock, reset        : sole clock; synchronous ACTIVE-LOW reset (0 = reset)
//   auto_in  (slave)    : inner port; A enters here, D leaves here
//   auto_out (master)   : outer port; A leaves here, D enters here
//   a_count/d_count, a_hwm/d_hwm : occupancy and high-water marks, present
//                                  only when TL_BUFFER_STATS_EN is defined
// Each channel is a tl_buffer_fifo: depth 0 = wire, otherwise an N-entry queue
// with optional flow (bypass when empty) and pipe (enq while full+deq) modes.
module tl_buffer_queue
  import tl_buffer_pkg::*;
#(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned D_DEPTH = 2,
  parameter bit          A_FLOW  = 1'b0,
  parameter bit          D_FLOW  = 1'b0,
  parameter bit          A_PIPE  = 1'b0,
  parameter bit          D_PIPE  = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  tl_buffer_queue_if.slave     auto_in,
  tl_buffer_queue_if.master    auto_out
`ifdef TL_BUFFER_STATS_EN
  ,
  output logic [cnt_w(A_DEPTH)-1:0] a_count,
  output logic [cnt_w(D_DEPTH)-1:0] d_count,
  output logic [cnt_w(A_DEPTH)-1:0] a_hwm,
  output logic [cnt_w(D_DEPTH)-1:0] d_hwm
`endif
);

  tl_buffer_fifo #(.DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .T(tl_a_t)) u_a (
    .clk_i       (clock),
    .rst_ni      (reset),
    .enq_valid_i (auto_in.a_valid),
    .enq_ready_o (auto_in.a_ready),
    .enq_bits_i  (auto_in.a_bits),
    .deq_valid_o (auto_out.a_valid),
    .deq_ready_i (auto_out.a_ready),
    .deq_bits_o  (auto_out.a_bits)
`ifdef TL_BUFFER_STATS_EN
    ,
    .count_o     (a_count),
    .hwm_o       (a_hwm)
`endif
  );

  tl_buffer_fifo #(.DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .T(tl_d_t)) u_d (
    .clk_i       (clock),
    .rst_ni      (reset),
    .enq_valid_i (auto_out.d_valid),
    .enq_ready_o (auto_out.d_ready),
    .enq_bits_i  (auto_out.d_bits),
    .deq_valid_o (auto_in.d_valid),
    .deq_ready_i (auto_in.d_ready),
    .deq_bits_o  (auto_in.d_bits)
`ifdef TL_BUFFER_STATS_EN
    ,
    .count_o     (d_count),
    .hwm_o       (d_hwm)
`endif
  );

endmodule

// File: tb/tb_tl_buffer_queue.sv
// Directed bench for tl_buffer_queue across three configurations:
//   dut0: A_DEPTH=2, D_DEPTH=0             (backpressure, pass-through, reset)
//   dut1: A_DEPTH=3 A_FLOW=1, D_DEPTH=3    (flow bypass, non-pow2 wrap)
//   dut2: A_DEPTH=1 A_PIPE=1, D_DEPTH=2    (pipe throughput)
module tb_tl_buffer_queue;
  import tl_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tl_buffer_queue_if in0 (), out0 (), in1 (), out1 (), in2 (), out2 ();

`ifdef TL_BUFFER_STATS_EN
  logic [cnt_w(2)-1:0] a_cnt0, a_hwm0;
  logic [cnt_w(0)-1:0] d_cnt0, d_hwm0;
  logic [cnt_w(3)-1:0] a_cnt1, a_hwm1, d_cnt1, d_hwm1;
  logic [cnt_w(1)-1:0] a_cnt2, a_hwm2;
  logic [cnt_w(2)-1:0] d_cnt2, d_hwm2;
`endif

  tl_buffer_queue #(.A_DEPTH(2), .D_DEPTH(0)) dut0 (
    .clock(clk), .reset(rst), .auto_in(in0), .auto_out(out0)
`ifdef TL_BUFFER_STATS_EN
    , .a_count(a_cnt0), .d_count(d_cnt0), .a_hwm(a_hwm0), .d_hwm(d_hwm0)
`endif
  );

  tl_buffer_queue #(.A_DEPTH(3), .A_FLOW(1'b1), .D_DEPTH(3)) dut1 (
    .clock(clk), .reset(rst), .auto_in(in1), .auto_out(out1)
`ifdef TL_BUFFER_STATS_EN
    , .a_count(a_cnt1), .d_count(d_cnt1), .a_hwm(a_hwm1), .d_hwm(d_hwm1)
`endif
  );

  tl_buffer_queue #(.A_DEPTH(1), .A_PIPE(1'b1), .D_DEPTH(2)) dut2 (
    .clock(clk), .reset(rst), .auto_in(in2), .auto_out(out2)
`ifdef TL_BUFFER_STATS_EN
    , .a_count(a_cnt2), .d_count(d_cnt2), .a_hwm(a_hwm2), .d_hwm(d_hwm2)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled mid-cycle, after the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic tl_a_t mk_a(input logic [2:0] op, input logic [5:0] src, input logic [28:0] addr);
    tl_a_t a;
    a = '0;
    a.opcode = op; a.source = src; a.address = addr; a.mask = 8'hFF; a.size = 4'd3;
    return a;
  endfunction

  function automatic tl_d_t mk_d(input logic [2:0] op, input logic [5:0] src, input logic [63:0] data);
    tl_d_t d;
    d = '0;
    d.opcode = op; d.source = src; d.data = data; d.size = 4'd3;
    return d;
  endfunction

  initial begin
    in0.a_valid = 0; in0.a_bits = '0; in0.d_ready = 0;
    out0.a_ready = 0; out0.d_valid = 0; out0.d_bits = '0;
    in1.a_valid = 0; in1.a_bits = '0; in1.d_ready = 0;
    out1.a_ready = 0; out1.d_valid = 0; out1.d_bits = '0;
    in2.a_valid = 0; in2.a_bits = '0; in2.d_ready = 0;
    out2.a_ready = 0; out2.d_valid = 0; out2.d_bits = '0;

    // ---- reset: handshakes forced low, even through the D wire ----
    tick(); tick();
    out0.d_valid = 1; in0.d_ready = 1;
    #1;
    chk("rst_in0_a_ready", in0.a_ready, 0);
    chk("rst_out0_a_valid", out0.a_valid, 0);
    chk("rst_in0_d_valid", in0.d_valid, 0);
    chk("rst_out0_d_ready", out0.d_ready, 0);
    chk("rst_out1_a_valid", out1.a_valid, 0);
    out0.d_valid = 0; in0.d_ready = 0;
    rst = 1;
    #1;
    chk("rel_in0_a_ready", in0.a_ready, 1);
    chk("rel_in1_d_valid", in1.d_valid, 0);

    // ---- 1: depth-2 backpressure then drain in order ----
    tick();
    out0.a_ready = 0;
    in0.a_valid = 1; in0.a_bits = mk_a(TL_A_GET, 6'd5, 29'h40);
    #1 chk("t1_ready_e0", in0.a_ready, 1);
    tick();
    in0.a_bits = mk_a(TL_A_GET, 6'd6, 29'h48);
    #1;
    chk("t1_ready_e1", in0.a_ready, 1);
    chk("t1_head_src", out0.a_bits.source, 5);
    tick();
    in0.a_valid = 0;
    #1 chk("t1_full_ready", in0.a_ready, 0);
    out0.a_ready = 1;
    #1;
    chk("t1_out_v0", out0.a_valid, 1);
    chk("t1_out_src0", out0.a_bits.source, 5);
    chk("t1_out_op0", out0.a_bits.opcode, TL_A_GET);
    tick();
    #1;
    chk("t1_out_v1", out0.a_valid, 1);
    chk("t1_out_src1", out0.a_bits.source, 6);
    chk("t1_out_addr1", out0.a_bits.address, 29'h48);
    tick();
    #1 chk("t1_drained", out0.a_valid, 0);
    out0.a_ready = 0;

    // ---- 2: depth-0 D channel is a wire ----
    out0.d_valid = 1; out0.d_bits = mk_d(TL_D_ACCESSACKDATA, 6'd3, 64'hDEADBEEF_CAFEF00D);
    in0.d_ready = 0;
    #1;
    chk("t2_d_valid", in0.d_valid, 1);
    chk("t2_d_data", in0.d_bits.data, 64'hDEADBEEF_CAFEF00D);
    chk("t2_d_op", in0.d_bits.opcode, TL_D_ACCESSACKDATA);
    chk("t2_d_ready_lo", out0.d_ready, 0);
    in0.d_ready = 1;
    #1 chk("t2_d_ready_hi", out0.d_ready, 1);
    tick();
    out0.d_valid = 0; in0.d_ready = 0;

    // ---- 3: flow bypass on empty depth-3 A queue ----
    out1.a_ready = 1;
    in1.a_valid = 1; in1.a_bits = mk_a(TL_A_PUTFULL, 6'd1, 29'h1000);
    #1;
    chk("t3_flow_valid", out1.a_valid, 1);
    chk("t3_flow_addr", out1.a_bits.address, 29'h1000);
`ifdef TL_BUFFER_STATS_EN
    chk("t3_cnt_same", a_cnt1, 0);
`endif
    tick();
    in1.a_valid = 0;
    #1 chk("t3_nothing_stored", out1.a_valid, 0);
`ifdef TL_BUFFER_STATS_EN
    chk("t3_cnt_after", a_cnt1, 0);
`endif
    // flow with consumer stalled: beat must be written
    out1.a_ready = 0;
    in1.a_valid = 1; in1.a_bits = mk_a(TL_A_PUTFULL, 6'd2, 29'h2000);
    tick();
    in1.a_valid = 0;
    #1;
    chk("t3_stored_valid", out1.a_valid, 1);
    chk("t3_stored_addr", out1.a_bits.address, 29'h2000);
    out1.a_ready = 1;
    tick();
    #1 chk("t3_stored_drained", out1.a_valid, 0);
    out1.a_ready = 0;

    // ---- 5: depth-3 D queue wraps: fill 3, drain 2, refill 2, drain ----
    in1.d_ready = 0;
    for (int i = 0; i < 3; i++) begin
      out1.d_valid = 1; out1.d_bits = mk_d(TL_D_ACCESSACK, 6'(i), 64'(i));
      tick();
    end
    out1.d_valid = 0;
    #1 chk("t5_full", out1.d_ready, 0);
    in1.d_ready = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk($sformatf("t5_src%0d", i), in1.d_bits.source, i);
      tick();
    end
    in1.d_ready = 0;
    out1.d_valid = 1; out1.d_bits = mk_d(TL_D_ACCESSACK, 6'd3, 64'd3);
    #1 chk("t5_refill_ready", out1.d_ready, 1);
    tick();
    out1.d_bits = mk_d(TL_D_ACCESSACK, 6'd4, 64'd4);
    tick();
    out1.d_valid = 0;
    #1 chk("t5_full2", out1.d_ready, 0);
    in1.d_ready = 1;
    for (int i = 2; i < 5; i++) begin
      #1 chk($sformatf("t5_src%0d", i), in1.d_bits.source, i);
      tick();
    end
    #1 chk("t5_empty", in1.d_valid, 0);
    in1.d_ready = 0;

    // ---- 4: depth-1 pipe sustains one beat per cycle ----
    out2.a_ready = 0;
    in2.a_valid = 1; in2.a_bits = mk_a(TL_A_GET, 6'd0, 29'h0);
    tick();
    in2.a_bits = mk_a(TL_A_GET, 6'd1, 29'h8);
    #1 chk("t4_full_no_deq", in2.a_ready, 0);
    out2.a_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      in2.a_bits = mk_a(TL_A_GET, 6'(k), 29'(k * 8));
      #1;
      chk($sformatf("t4_ready%0d", k), in2.a_ready, 1);
      chk($sformatf("t4_src%0d", k - 1), out2.a_bits.source, k - 1);
      tick();
    end
    in2.a_valid = 0;
    #1 chk("t4_last_src", out2.a_bits.source, 8);
    tick();
    #1 chk("t4_empty", out2.a_valid, 0);
    out2.a_ready = 0;

    // ---- 6: reset with two entries queued ----
    in0.a_valid = 1; in0.a_bits = mk_a(TL_A_GET, 6'd7, 29'h70);
    tick();
    in0.a_bits = mk_a(TL_A_GET, 6'd8, 29'h78);
    tick();
    in0.a_valid = 0;
    tick();
    #1 chk("t6_pre_valid", out0.a_valid, 1);
`ifdef TL_BUFFER_STATS_EN
    chk("t6_pre_hwm", a_hwm0, 2);
`endif
    rst = 0;
    #1;
    chk("t6_rst_valid", out0.a_valid, 0);
    chk("t6_rst_ready", in0.a_ready, 0);
    tick();
    rst = 1;
    #1;
    chk("t6_post_ready", in0.a_ready, 1);
    chk("t6_post_valid", out0.a_valid, 0);
`ifdef TL_BUFFER_STATS_EN
    chk("t6_post_hwm", a_hwm0, 0);
`endif
    out0.a_ready = 1;
    tick();
    #1 chk("t6_still_empty", out0.a_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
